// File: rtl/if_id_queue.sv
// Fetch-to-decode buffer: first-word-fall-through FIFO of {pc, instr} entries.
// Empty head reads as PC 0 carrying a NOP so decode sees a harmless bubble.
module if_id_queue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       flush_in,
   input  logic                       in_valid_in,
   input  logic [WIDTH-1:0]           in_pc_in,
   input  logic [31:0]                in_instr_in,
   output logic                       stall_out,
   output logic                       out_valid_out,
   input  logic                       out_ready_in,
   output logic [WIDTH-1:0]           out_pc_out,
   output logic [31:0]                out_instr_out,
   output logic [WIDTH-1:0]           out_pc_plus4_out,
   output logic [$clog2(DEPTH):0]     count_out
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [31:0]   NOP_INSTR  = 32'h0000_0013;

   logic [WIDTH-1:0] mem_pc    [DEPTH];
   logic [31:0]      mem_instr [DEPTH];

   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;

   logic full;
   logic empty;
   logic push;
   logic pop;

   // Full/empty come only from registered count, so stall has no input path.
   assign full  = (count == FULL_COUNT);
   assign empty = (count == '0);
   assign push  = in_valid_in && !full;
   assign pop   = !empty && out_ready_in;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush_in) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; a flushed push must not land in the array either.
   always_ff @(posedge clk_in) begin
      if (push && !flush_in) begin
         mem_pc[wr_ptr]    <= in_pc_in;
         mem_instr[wr_ptr] <= in_instr_in;
      end
   end

   always_comb begin
      out_pc_out    = '0;
      out_instr_out = NOP_INSTR;
      if (!empty) begin
         out_pc_out    = mem_pc[rd_ptr];
         out_instr_out = mem_instr[rd_ptr];
      end
   end

   assign out_pc_plus4_out = out_pc_out + WIDTH'(4);
   assign out_valid_out    = !empty;
   assign stall_out        = full;
   assign count_out        = count;

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, address/PC width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, entry count; legal values are powers of two >= 2.
REQ-003 SHALL have port clk_in  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rst_in  input  1  asynchronous active-low reset.
REQ-005 SHALL have port flush_in  input  1  discard all entries (taken branch/jump redirect).
REQ-006 SHALL have port in_valid_in  input  1  fetch stage presents a fetched instruction.
REQ-007 SHALL have port in_pc_in  input  WIDTH  PC of the fetched instruction.
REQ-008 SHALL have port in_instr_in  input  32  fetched instruction word.
REQ-009 SHALL have port stall_out  output  1  fetch must hold its PC (queue full).
REQ-010 SHALL have port out_valid_out  output  1  head entry valid for decode.
REQ-011 SHALL have port out_ready_in  input  1  decode accepts the head entry.
REQ-012 SHALL have port out_pc_out  output  WIDTH  PC of the head entry.
REQ-013 SHALL have port out_instr_out  output  32  instruction of the head entry.
REQ-014 SHALL have port out_pc_plus4_out  output  WIDTH  head PC + 4.
REQ-015 SHALL have port count_out  output  clog2(DEPTH)+1  occupied entries.

Function
REQ-016 SHALL be a first-word-fall-through FIFO of {pc, instr} entries with read/write pointers and occupancy counter.
REQ-017 SHALL drive stall_out = (count == DEPTH), derived from registered state only (no combinational path from any input).
REQ-018 SHALL accept a push when in_valid_in=1 and count<DEPTH; in_valid_in while full is ignored, entry not stored.
REQ-019 SHALL pop the head when out_valid_out=1 and out_ready_in=1.
REQ-020 SHALL drive out_valid_out = (count != 0).
REQ-021 SHALL present an entry pushed at edge N on the outputs after edge N (one-cycle latency); no same-cycle input-to-output bypass.
REQ-022 SHALL, on simultaneous push and pop with 0<count<DEPTH, keep count unchanged and advance both pointers.
REQ-023 SHALL not accept a push while full even if a pop occurs in the same cycle (stall_out already asserted).
REQ-024 SHALL wrap pointers modulo DEPTH.
REQ-025 SHALL, when flush_in=1 at an edge, set count and both pointers to 0 and discard any simultaneous push and pop; flush has priority over all other events.
REQ-026 SHALL, when count==0, drive out_pc_out=0 and out_instr_out=32'h00000013 (NOP).
REQ-027 SHALL compute out_pc_plus4_out = out_pc_out + 4, truncated to WIDTH bits (wraps at 2^WIDTH).
REQ-028 SHALL never change count by more than one per cycle except on flush.

Reset
REQ-029 SHALL, while rst_in=0, immediately (asynchronously) clear count and pointers; outputs read: stall_out=0, out_valid_out=0, count_out=0, out_pc_out=0, out_instr_out=32'h00000013, out_pc_plus4_out=4.
REQ-030 SHALL synchronously resume normal operation at the first rising edge after rst_in deasserts; reset asserted mid-operation discards all entries.
REQ-031 SHALL not require storage array contents to be reset.

Verification
REQ-032 SHALL cover fill: out_ready_in=0, push pc 0x0,0x4 with instrs 0xAAAA0001,0xAAAA0002 -> count 1 then 2, stall_out=1 after second edge, head pc 0x0 instr 0xAAAA0001, pc_plus4 0x4.
REQ-033 SHALL cover full drop: full, in_valid_in=1 pc 0x8 -> entry discarded; after draining two pops, out_valid_out=0 and pc 0x8 never appears.
REQ-034 SHALL cover streaming: count=1, push and pop every cycle for 10 cycles, pcs 0x100.. step 4 -> count stays 1, outputs emit pcs in order with one-cycle lag, pointers wrap correctly.
REQ-035 SHALL cover flush: count=2 with push+pop and flush_in=1 in same cycle -> next cycle count=0, out_valid_out=0, out_instr_out=0x00000013; following push pc 0x200 appears next cycle.
REQ-036 SHALL cover async reset mid-operation: count=2, drive rst_in=0 between edges -> count_out=0, stall_out=0 before next edge; release -> normal push works.
REQ-037 SHALL cover wrap: head pc 0xFFFFFFFC -> out_pc_plus4_out=0x00000000.
